// File: rtl/lfsr_pkg.sv
// Shared constants, control decode type and software reference step for the
// 80-bit Fibonacci LFSR.
package lfsr_pkg;

  localparam int unsigned LFSR_WIDTH = 80;

  // Tap positions into the state; bit 0 is the output end.
  localparam int unsigned TAP0 = 0;
  localparam int unsigned TAP1 = 1;
  localparam int unsigned TAP2 = 37;
  localparam int unsigned TAP3 = 38;

  // Nonzero so that the register cannot start in the all-zero lock-up state.
  localparam logic [LFSR_WIDTH-1:0] LFSR_RESET_VAL = LFSR_WIDTH'(1);

  // Per-cycle action after reset has been resolved.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_SHIFT = 2'd1,
    OP_LOAD  = 2'd2
  } lfsr_op_e;

  // Reference single step: right shift with feedback entering at the top.
  function automatic logic [LFSR_WIDTH-1:0] next_state(input logic [LFSR_WIDTH-1:0] s);
    logic fb;
    fb = s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3];
    return {fb, s[LFSR_WIDTH-1:1]};
  endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// Combinational feedback bit: XOR-reduce of the tapped state bits.
module lfsr_feedback
  import lfsr_pkg::*;
(
  input  logic [3:0] taps_i,
  output logic       fb_o
);

  // Parity of the four taps.
  always_comb begin
    fb_o = ^taps_i;
  end

endmodule

// File: rtl/lfsr.sv
// 80-bit Fibonacci LFSR with synchronous parallel load, serial and parallel
// outputs. Priority per edge: reset > load > shift > hold.
module lfsr
  import lfsr_pkg::*;
#(
  parameter int unsigned             WIDTH     = LFSR_WIDTH,
  parameter logic [LFSR_WIDTH-1:0]   RESET_VAL = LFSR_RESET_VAL
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             Par_load,
  input  logic [WIDTH-1:0] Seed,
  output logic [WIDTH-1:0] Par_out,
  output logic             Ser_out
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [3:0]       taps;
  logic             fb;
  lfsr_op_e         op;

  assign taps = {state_q[TAP3], state_q[TAP2], state_q[TAP1], state_q[TAP0]};

  lfsr_feedback u_feedback (
    .taps_i (taps),
    .fb_o   (fb)
  );

  // Decode the requested action; load outranks shift.
  always_comb begin
    op = OP_HOLD;
    if (Par_load) begin
      op = OP_LOAD;
    end else if (shift_en) begin
      op = OP_SHIFT;
    end
  end

  // Next-state mux for the selected action.
  always_comb begin
    state_d = state_q;
    unique case (op)
      OP_LOAD:  state_d = Seed;
      OP_SHIFT: state_d = {fb, state_q[WIDTH-1:1]};
      default:  state_d = state_q;
    endcase
  end

  // State register; the active-low reset overrides any load or shift.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RESET_VAL[WIDTH-1:0];
    end else begin
      state_q <= state_d;
    end
  end

  assign Par_out = state_q;
  assign Ser_out = state_q[0];

endmodule

// File: tb/tb_lfsr.sv
// Directed self-checking bench for the 80-bit LFSR.
module tb_lfsr;
  import lfsr_pkg::*;

  logic        clk;
  logic        rst;
  logic        shift_en;
  logic        Par_load;
  logic [79:0] Seed;
  logic [79:0] Par_out;
  logic        Ser_out;

  int checks;
  int failures;

  logic [79:0] model;
  logic [79:0] held;

  localparam logic [79:0] RST_EXP   = 80'h0000_0000_0000_0000_0001;
  localparam logic [79:0] SEED_A    = 80'h1234_5678_9ABC_DEF0_1234;
  localparam logic [79:0] SHIFT_A   = 80'h891A_2B3C_4D5E_6F78_091A;
  localparam logic [79:0] SEED_B    = 80'hA5A5_0F0F_C3C3_5A5A_FFFF;
  localparam logic [79:0] TOP_ONE   = 80'h8000_0000_0000_0000_0000;

  lfsr #(
    .WIDTH     (80),
    .RESET_VAL (80'h1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .Par_load (Par_load),
    .Seed     (Seed),
    .Par_out  (Par_out),
    .Ser_out  (Ser_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent bench model of one shift step.
  function automatic logic [79:0] tb_step(input logic [79:0] s);
    logic fb;
    fb = s[0] ^ s[1] ^ s[37] ^ s[38];
    return {fb, s[79:1]};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling / changing inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    shift_en = 1'b0;
    Par_load = 1'b0;
    Seed     = '0;
    step();

    // Reset with a concurrent load: reset wins.
    rst      = 1'b0;
    Par_load = 1'b1;
    Seed     = SEED_B;
    step();
    chk("reset_par", Par_out, RST_EXP);
    chk("reset_ser", 80'(Ser_out), 80'h1);

    // Parallel load.
    rst      = 1'b1;
    Par_load = 1'b1;
    Seed     = SEED_A;
    step();
    chk("load_par", Par_out, SEED_A);
    chk("load_ser", 80'(Ser_out), 80'h0);

    // First shift, hand-computed (fb = 1).
    Par_load = 1'b0;
    shift_en = 1'b1;
    step();
    chk("shift1_par", Par_out, SHIFT_A);
    chk("shift1_ser", 80'(Ser_out), 80'h0);
    chk("pkg_next_state", next_state(SEED_A), SHIFT_A);

    // Ten more shifts against the bench model.
    model = SHIFT_A;
    for (int i = 0; i < 10; i++) begin
      step();
      model = tb_step(model);
      chk("run_par", Par_out, model);
      chk("run_ser", 80'(Ser_out), 80'(model[0]));
    end

    // Hold for two cycles.
    shift_en = 1'b0;
    held     = model;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hold_par", Par_out, held);
      chk("hold_ser", 80'(Ser_out), 80'(held[0]));
    end

    // Resume where the sequence stopped.
    shift_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      model = tb_step(model);
      chk("resume_par", Par_out, model);
      chk("resume_ser", 80'(Ser_out), 80'(model[0]));
    end

    // Load beats shift.
    Par_load = 1'b1;
    shift_en = 1'b1;
    Seed     = SEED_B;
    step();
    chk("prio_load_par", Par_out, SEED_B);

    // Reset beats load and shift mid-stream.
    rst  = 1'b0;
    Seed = SEED_A;
    step();
    chk("prio_rst_par", Par_out, RST_EXP);

    // All-zero lock-up.
    rst      = 1'b1;
    Par_load = 1'b1;
    shift_en = 1'b0;
    Seed     = '0;
    step();
    chk("zero_load_par", Par_out, 80'h0);
    Par_load = 1'b0;
    shift_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lock_par", Par_out, 80'h0);
      chk("lock_ser", 80'(Ser_out), 80'h0);
    end

    // Reload of 1 restores stepping.
    Par_load = 1'b1;
    shift_en = 1'b0;
    Seed     = 80'h1;
    step();
    chk("reload_par", Par_out, 80'h1);
    chk("reload_ser", 80'(Ser_out), 80'h1);
    Par_load = 1'b0;
    shift_en = 1'b1;
    step();
    chk("recover_par", Par_out, TOP_ONE);
    chk("recover_ser", 80'(Ser_out), 80'h0);

    shift_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
